i2s_tx_master: RTL and testbench
================================

Name: i2s_tx_master

Overview:
- I2S bus master transmitter for the S3 FLL I2S project.
- Divides the local IP clock down to bitclk, generates LRCLK, and serializes stereo samples that the M4 pushes over Wishbone into a small frame FIFO.
- Exports a free-running frame counter, `wordcnt_o`. The FLL comparator on the receive side checks this counter against the master word count to raise speedup/slowdown interrupts.

Parameters:
- CLK_DIV, 4, CLK_IP_i cycles per bitclk half-period (>=1).
- DATA_WIDTH, 16, sample width in bits (<= SLOT_WIDTH-1).
- SLOT_WIDTH, 32, bitclk periods per channel slot.
- FIFO_DEPTH, 8, stereo frames buffered (power of 2).
- WORDCNT_WIDTH, 16, width of the frame counter.

Ports:
- CLK_IP_i  in  1  local IP clock (bitclk_local domain); sole clock.
- RST_IP_n_i  in  1  asynchronous, active-low reset.
- enable_i  in  1  level: start/continue transmission.
- sample_wr_i  in  1  one-cycle push strobe for a stereo frame.
- sample_l_i  in  DATA_WIDTH  left sample, two's complement.
- sample_r_i  in  DATA_WIDTH  right sample.
- fifo_full_o  out  1  FIFO holds FIFO_DEPTH frames.
- fifo_level_o  out  log2(FIFO_DEPTH)+1  frames stored.
- sticky_clr_i  in  1  clears underrun_o and overflow_o.
- underrun_o  out  1  sticky: a pop was attempted while the FIFO was empty.
- overflow_o  out  1  sticky: a push arrived while the FIFO was full.
- bitclk_o  out  1  I2S serial clock.
- lrclk_o  out  1  word select; 0 = left.
- sdata_o  out  1  serial data, MSB first.
- wordcnt_o  out  WORDCNT_WIDTH  completed-frame counter.
- busy_o  out  1  state != IDLE.

Behaviour:
- Reset (RST_IP_n_i=0, async):
  - State = IDLE, FIFO emptied.
  - `bitclk_o`, `lrclk_o`, `sdata_o`, `underrun_o`, `overflow_o`, `busy_o` = 0; `wordcnt_o` = 0; `fifo_level_o` = 0; `fifo_full_o` = 0.
  - Internal div_cnt = 0, bit_idx = 0.
- All outputs are registered. Timing below is in CLK_IP_i rising edges.
- FIFO:
  - A push is accepted only if `fifo_full_o`=0 at that edge.
  - A push while full is dropped and sets `overflow_o`.
  - Push and pop in the same cycle are both honoured when not full; level is unchanged.
  - `sticky_clr_i` has priority below a same-cycle set (set wins).
- State machine IDLE / RUN / DRAIN:
  - IDLE: outputs held at 0, div_cnt = 0, bit_idx = 0. enable_i=1 -> RUN on the next edge.
  - RUN:
    - div_cnt counts 0..CLK_DIV-1; at terminal count `bitclk_o` toggles and div_cnt returns to 0.
    - First rise of `bitclk_o` occurs CLK_DIV cycles after entering RUN.
    - On each bitclk falling toggle, bit_idx advances modulo 2*SLOT_WIDTH.
    - On the same falling toggle, `lrclk_o` <= (new bit_idx >= SLOT_WIDTH) and `sdata_o` <= shift-register MSB, and the shift register shifts left (zero fill).
  - Loads (I2S one-bit delay):
    - At the fall entering bit_idx=1: pop one frame, load left sample MSB-aligned into the shift register, and store the right sample. That same fall drives the left MSB.
    - At bit_idx=SLOT_WIDTH+1: load the stored right sample, same way.
    - Slot bits beyond DATA_WIDTH are 0; bit_idx 0 and SLOT_WIDTH carry 0.
  - Empty FIFO at a pop: transmit zeros for both channels of that frame and set `underrun_o`. The FIFO is not modified.
  - `wordcnt_o` increments, wrapping, on each bit_idx wrap 2*SLOT_WIDTH-1 -> 0. Entering RUN does not count.
  - enable_i=0 in RUN -> DRAIN.
  - DRAIN: continues as RUN but does not pop again. At the bit_idx wrap to 0 (frame completes, `wordcnt_o` increments), go to IDLE with `bitclk_o`=0.
  - enable_i=1 in DRAIN -> RUN (no gap).
- Frames are never truncated except by reset.

Test Plan:
- Reset mid-frame:
  - Stimulus: assert RST_IP_n_i low at bit_idx=17.
  - Required: all outputs 0 asynchronously; `fifo_level_o`=0; after release and enable, the next frame starts at bit_idx 0.
- Basic frame (CLK_DIV=2, SLOT=32, DATA=16):
  - Stimulus: push L=0xA5C3, R=0x1234, then enable.
  - Required: `bitclk_o` period = 4 clocks. Left data 1010010111000011 appears on bits 1..16 with `lrclk_o`=0; right data 0x1234 appears on bits 33..48 with `lrclk_o`=1; all other bits 0. After 256 clocks, `wordcnt_o`=1 and `fifo_level_o`=0.
- Underrun:
  - Stimulus: enable with an empty FIFO for 2 frames; push one frame mid-second-frame.
  - Required: `sdata_o` all 0 for frames 1–2; `underrun_o`=1; frame 3 carries the pushed data; `sticky_clr_i` pulse -> `underrun_o`=0.
- Overflow and simultaneous events:
  - Stimulus: FIFO_DEPTH+1 pushes while disabled.
  - Required: `fifo_full_o`=1, `overflow_o`=1, level=8. A push coincident with a pop while not full keeps the level unchanged.
- Drain:
  - Stimulus: drop enable_i at bit_idx=40.
  - Required: frame completes through bit 63; `wordcnt_o` +1; state IDLE and `busy_o`=0 within 1 clock of the wrap; no further pop occurs.
- Counter wrap:
  - Stimulus: WORDCNT_WIDTH=4, run 17 frames.
  - Required: `wordcnt_o` reads 0xF then 0x0 then 0x1.

Source files
------------

// File: rtl/i2s_tx_master.sv
// i2s_tx_master: I2S master transmitter with frame FIFO, bitclk/LRCLK generation and frame counter.
module i2s_tx_master #(
    parameter int CLK_DIV       = 4,
    parameter int DATA_WIDTH    = 16,
    parameter int SLOT_WIDTH    = 32,
    parameter int FIFO_DEPTH    = 8,
    parameter int WORDCNT_WIDTH = 16
) (
    input  logic                         CLK_IP_i,
    input  logic                         RST_IP_n_i,
    input  logic                         enable_i,
    input  logic                         sample_wr_i,
    input  logic [DATA_WIDTH-1:0]        sample_l_i,
    input  logic [DATA_WIDTH-1:0]        sample_r_i,
    output logic                         fifo_full_o,
    output logic [$clog2(FIFO_DEPTH):0]  fifo_level_o,
    input  logic                         sticky_clr_i,
    output logic                         underrun_o,
    output logic                         overflow_o,
    output logic                         bitclk_o,
    output logic                         lrclk_o,
    output logic                         sdata_o,
    output logic [WORDCNT_WIDTH-1:0]     wordcnt_o,
    output logic                         busy_o
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int LW = AW + 1;
    localparam int IW = $clog2(2 * SLOT_WIDTH);
    localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [CW-1:0] DIV_LAST = CW'(CLK_DIV - 1);
    localparam logic [IW-1:0] IDX_LAST = IW'(2 * SLOT_WIDTH - 1);
    localparam logic [IW-1:0] IDX_SLOT = IW'(SLOT_WIDTH);
    localparam logic [IW-1:0] IDX_L    = IW'(1);
    localparam logic [IW-1:0] IDX_R    = IW'(SLOT_WIDTH + 1);
    localparam logic [LW-1:0] LVL_FULL = LW'(FIFO_DEPTH);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

    state_t                    state_q, state_d;
    logic [CW-1:0]             div_q, div_d;
    logic [IW-1:0]             idx_q, idx_d, idx_nxt;
    logic [SLOT_WIDTH-1:0]     shift_q, shift_d, ld_word, sh_src;
    logic [DATA_WIDTH-1:0]     right_q, right_d, ld_val;
    logic [WORDCNT_WIDTH-1:0]  wordcnt_q, wordcnt_d;
    logic [AW-1:0]             wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [LW-1:0]             level_q, level_d;
    logic                      full_q, full_d, bitclk_q, bitclk_d, lrclk_q, lrclk_d;
    logic                      sdata_q, sdata_d, under_q, under_d, over_q, over_d, busy_q, busy_d;
    logic                      tick, fall, wrap, ld, pop_req, pop, push;
    logic [2*DATA_WIDTH-1:0]   mem_q [FIFO_DEPTH];
    logic [2*DATA_WIDTH-1:0]   head;

    assign head = mem_q[rd_ptr_q];
    assign push = sample_wr_i && !full_q;

    always_comb begin
        state_d   = state_q;
        div_d     = div_q;
        idx_d     = idx_q;
        shift_d   = shift_q;
        right_d   = right_q;
        wordcnt_d = wordcnt_q;
        bitclk_d  = bitclk_q;
        lrclk_d   = lrclk_q;
        sdata_d   = sdata_q;
        tick      = (state_q != IDLE) && (div_q == DIV_LAST);
        fall      = tick && bitclk_q;
        idx_nxt   = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
        wrap      = fall && (idx_q == IDX_LAST);
        ld        = (idx_nxt == IDX_L) || (idx_nxt == IDX_R);
        // Left sample is popped one bit after the LRCLK edge (I2S delay); right waits in right_q
        pop_req   = fall && (idx_nxt == IDX_L) && (state_q == RUN);
        pop       = pop_req && (level_q != '0);
        ld_val    = (idx_nxt == IDX_L) ? (pop ? head[2*DATA_WIDTH-1:DATA_WIDTH] : '0) : right_q;
        ld_word   = {ld_val, {(SLOT_WIDTH-DATA_WIDTH){1'b0}}};
        sh_src    = ld ? ld_word : shift_q;
        if (pop_req)
            right_d = pop ? head[DATA_WIDTH-1:0] : '0;
        if (state_q == IDLE) begin
            div_d    = '0;
            idx_d    = '0;
            shift_d  = '0;
            bitclk_d = 1'b0;
            lrclk_d  = 1'b0;
            sdata_d  = 1'b0;
            state_d  = enable_i ? RUN : IDLE;
        end else begin
            div_d    = tick ? '0 : div_q + 1'b1;
            bitclk_d = bitclk_q ^ tick;
            if (fall) begin
                idx_d     = idx_nxt;
                lrclk_d   = idx_nxt >= IDX_SLOT;
                sdata_d   = sh_src[SLOT_WIDTH-1];
                shift_d   = sh_src << 1;
                wordcnt_d = wordcnt_q + WORDCNT_WIDTH'(wrap);
            end
            state_d = enable_i ? RUN : (wrap ? IDLE : DRAIN);
        end
        wr_ptr_d = wr_ptr_q + AW'(push);
        rd_ptr_d = rd_ptr_q + AW'(pop);
        level_d  = level_q + LW'(push) - LW'(pop);
        full_d   = level_d == LVL_FULL;
        under_d  = (pop_req && !pop) || (under_q && !sticky_clr_i);
        over_d   = (sample_wr_i && full_q) || (over_q && !sticky_clr_i);
        busy_d   = state_d != IDLE;
    end

    always_ff @(posedge CLK_IP_i or negedge RST_IP_n_i) begin
        if (!RST_IP_n_i) begin
            state_q   <= IDLE;
            div_q     <= '0;
            idx_q     <= '0;
            shift_q   <= '0;
            right_q   <= '0;
            wordcnt_q <= '0;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            level_q   <= '0;
            full_q    <= 1'b0;
            bitclk_q  <= 1'b0;
            lrclk_q   <= 1'b0;
            sdata_q   <= 1'b0;
            under_q   <= 1'b0;
            over_q    <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            div_q     <= div_d;
            idx_q     <= idx_d;
            shift_q   <= shift_d;
            right_q   <= right_d;
            wordcnt_q <= wordcnt_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            level_q   <= level_d;
            full_q    <= full_d;
            bitclk_q  <= bitclk_d;
            lrclk_q   <= lrclk_d;
            sdata_q   <= sdata_d;
            under_q   <= under_d;
            over_q    <= over_d;
            busy_q    <= busy_d;
        end
    end

    always_ff @(posedge CLK_IP_i) begin
        if (push)
            mem_q[wr_ptr_q] <= {sample_l_i, sample_r_i};
    end

    assign fifo_full_o  = full_q;
    assign fifo_level_o = level_q;
    assign underrun_o   = under_q;
    assign overflow_o   = over_q;
    assign bitclk_o     = bitclk_q;
    assign lrclk_o      = lrclk_q;
    assign sdata_o      = sdata_q;
    assign wordcnt_o    = wordcnt_q;
    assign busy_o       = busy_q;
endmodule

// File: tb/tb_i2s_tx_master.sv
// tb_i2s_tx_master: directed stimulus with an expected-bit scoreboard checked on every bitclk rise.
module tb_i2s_tx_master;
    localparam int CLK_DIV = 2;

    logic        clk = 1'b0, rst_n = 1'b0, enable = 1'b0, wr = 1'b0, sclr = 1'b0;
    logic [15:0] sl = '0, sr = '0;
    logic        full, under, over, bclk, lrclk, sdata, busy;
    logic [3:0]  level, wcnt;

    typedef struct packed {logic [1:0] v; logic [7:0] idx;} exp_t;
    exp_t exp_q[$];
    int   n_cmp = 0, n_err = 0;

    i2s_tx_master #(.CLK_DIV(CLK_DIV), .DATA_WIDTH(16), .SLOT_WIDTH(32),
                    .FIFO_DEPTH(8), .WORDCNT_WIDTH(4)) dut (
        .CLK_IP_i(clk), .RST_IP_n_i(rst_n), .enable_i(enable), .sample_wr_i(wr),
        .sample_l_i(sl), .sample_r_i(sr), .fifo_full_o(full), .fifo_level_o(level),
        .sticky_clr_i(sclr), .underrun_o(under), .overflow_o(over), .bitclk_o(bclk),
        .lrclk_o(lrclk), .sdata_o(sdata), .wordcnt_o(wcnt), .busy_o(busy));

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [15:0] l, input logic [15:0] r);
        wr = 1'b1; sl = l; sr = r;
        cyc(1);
        wr = 1'b0;
    endtask

    // One frame as seen at successive bitclk rises: bit k = {lrclk, sdata}
    task automatic exp_frame(input logic [15:0] l, input logic [15:0] r);
        logic d;
        for (int k = 0; k < 64; k++) begin
            if (k >= 1 && k <= 16) d = l[16-k];
            else if (k >= 33 && k <= 48) d = r[48-k];
            else d = 1'b0;
            exp_q.push_back('{v: {k >= 32, d}, idx: 8'(k)});
        end
    endtask

    logic prev_bclk = 1'b0, have_rise = 1'b0;
    int   gap = 0;
    exp_t e;
    always @(negedge clk) begin
        if (!rst_n || !busy) have_rise = 1'b0;
        gap++;
        if (rst_n && bclk && !prev_bclk) begin
            if (have_rise) chk("bitclk_period", gap, 2 * CLK_DIV);
            have_rise = 1'b1;
            gap = 0;
            if (exp_q.size() == 0) chk("extra_bitclk_rise", 1, 0);
            else begin
                e = exp_q.pop_front();
                chk($sformatf("bit%0d", e.idx), {lrclk, sdata}, e.v);
            end
        end
        prev_bclk = bclk;
    end

    initial begin
        cyc(3);
        chk("rst_bitclk", bclk, 0);   chk("rst_lrclk", lrclk, 0);
        chk("rst_sdata", sdata, 0);   chk("rst_busy", busy, 0);
        chk("rst_wordcnt", wcnt, 0);  chk("rst_level", level, 0);
        chk("rst_full", full, 0);     chk("rst_under", under, 0);
        chk("rst_over", over, 0);
        rst_n = 1'b1;
        cyc(2);

        // Basic frame, then drain at bit 40 with a second frame left in the FIFO
        push(16'hA5C3, 16'h1234);
        push(16'h8001, 16'h7FFE);
        chk("a_level2", level, 2);
        exp_frame(16'hA5C3, 16'h1234);
        enable = 1'b1;
        cyc(1);
        chk("a_busy", busy, 1);
        cyc(161);
        enable = 1'b0;
        cyc(94);
        chk("a_wcnt_pre", wcnt, 0);   chk("a_busy_pre", busy, 1);
        cyc(1);
        chk("a_wcnt", wcnt, 1);       chk("a_busy_done", busy, 0);
        chk("a_bitclk", bclk, 0);     chk("a_level_nopop", level, 1);
        cyc(5);

        // Underrun: F2, two empty frames, F3 pushed mid third frame
        exp_frame(16'h8001, 16'h7FFE);
        exp_frame(16'h0000, 16'h0000);
        exp_frame(16'h0000, 16'h0000);
        exp_frame(16'h0F0F, 16'hF0F0);
        enable = 1'b1;
        cyc(1);
        cyc(640);
        chk("b_under_set", under, 1);
        wr = 1'b1; sl = 16'h0F0F; sr = 16'hF0F0;
        cyc(1);
        wr = 1'b0;
        chk("b_level1", level, 1);    chk("b_under_held", under, 1);
        sclr = 1'b1;
        cyc(1);
        sclr = 1'b0;
        chk("b_under_clr", under, 0);
        cyc(287);
        enable = 1'b0;
        cyc(95);
        chk("b_wcnt", wcnt, 5);       chk("b_busy", busy, 0);
        chk("b_level0", level, 0);    chk("b_under_final", under, 0);
        cyc(5);

        // Overflow, set-over-clear priority, push coincident with pop
        for (int i = 0; i < 8; i++) begin
            chk("c_full_before", full, 0);
            push(16'h1000 + 16'(i), 16'h2000 + 16'(i));
        end
        chk("c_full", full, 1);       chk("c_level8", level, 8);
        chk("c_over0", over, 0);
        sclr = 1'b1;
        push(16'hDEAD, 16'hBEEF);
        sclr = 1'b0;
        chk("c_over_set", over, 1);   chk("c_level_still8", level, 8);
        sclr = 1'b1;
        cyc(1);
        sclr = 1'b0;
        chk("c_over_clr", over, 0);
        exp_frame(16'h1000, 16'h2000);
        exp_frame(16'h1001, 16'h2001);
        enable = 1'b1;
        cyc(1);
        cyc(4);
        chk("c_level7", level, 7);    chk("c_full0", full, 0);
        cyc(255);
        wr = 1'b1; sl = 16'h3C3C; sr = 16'hC3C3;
        cyc(1);
        wr = 1'b0;
        chk("c_level_pushpop", level, 7);
        chk("c_over_none", over, 0);
        cyc(157);
        enable = 1'b0;
        cyc(95);
        chk("c_wcnt", wcnt, 7);       chk("c_busy", busy, 0);
        chk("c_level_end", level, 7);
        cyc(5);

        // Reset mid-frame at bit 17
        exp_frame(16'h1002, 16'h2002);
        enable = 1'b1;
        cyc(1);
        cyc(68);
        chk("d_bits_seen", exp_q.size(), 47);
        rst_n = 1'b0;
        enable = 1'b0;
        #1;
        chk("d_bitclk", bclk, 0);     chk("d_lrclk", lrclk, 0);
        chk("d_sdata", sdata, 0);     chk("d_busy", busy, 0);
        chk("d_wcnt", wcnt, 0);       chk("d_level", level, 0);
        chk("d_full", full, 0);       chk("d_under", under, 0);
        chk("d_over", over, 0);
        exp_q.delete();
        cyc(2);
        rst_n = 1'b1;
        cyc(3);
        chk("d_idle_after", busy, 0);

        // Counter wrap over 17 frames (4-bit counter)
        push(16'hFFFF, 16'h8000);
        chk("e_level1", level, 1);
        exp_frame(16'hFFFF, 16'h8000);
        for (int i = 0; i < 16; i++) exp_frame(16'h0000, 16'h0000);
        enable = 1'b1;
        cyc(1);
        cyc(3840);
        chk("e_wcnt_F", wcnt, 4'hF);
        cyc(256);
        chk("e_wcnt_0", wcnt, 4'h0);
        chk("e_under", under, 1);
        cyc(161);
        enable = 1'b0;
        cyc(95);
        chk("e_wcnt_1", wcnt, 4'h1);  chk("e_busy", busy, 0);
        cyc(20);
        chk("exp_q_empty", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
